// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and arbiter state type for mem_port_arbiter
package mem_arb_pkg;
  localparam int MEM_DATA_W = 64;
  localparam int INST_W = 32;
  localparam int WSTRB_W = 8;
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for one req/ack memory port (i_if_* fetch, i_d_* data, o_mem_*/i_mem_* memory side)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_if_req,
  input  logic [ADDR_W-1:0]  i_if_addr,
  input  logic               i_if_flush,
  output logic [INST_W-1:0]  o_if_rdata,
  output logic               o_if_valid,
  output logic               o_if_stall,
  input  logic               i_d_req,
  input  logic               i_d_we,
  input  logic [ADDR_W-1:0]  i_d_addr,
  input  logic [DATA_W-1:0]  i_d_wdata,
  input  logic [WSTRB_W-1:0] i_d_wstrb,
  output logic [DATA_W-1:0]  o_d_rdata,
  output logic               o_d_valid,
  output logic               o_d_stall,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic [WSTRB_W-1:0] o_mem_wstrb,
  input  logic               i_mem_ack,
  input  logic [DATA_W-1:0]  i_mem_rdata
);
  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);
  state_e state_q, state_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic drop_q, drop_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WSTRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [INST_W-1:0] if_rdata_q, if_rdata_d;
  logic if_valid_q, if_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic d_valid_q, d_valid_d;
  logic ack, data_wins;
  assign ack = mem_req_q && i_mem_ack;
  assign data_wins = i_d_req && !(i_if_req && run_cnt_q == RUN_MAX);
  always_comb begin
    state_d = state_q;
    run_cnt_d = run_cnt_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (data_wins) begin
        state_d = D_BUSY;
        mem_req_d = 1'b1;
        mem_we_d = i_d_we;
        mem_addr_d = i_d_addr;
        mem_wdata_d = i_d_wdata;
        mem_wstrb_d = i_d_wstrb;
        run_cnt_d = (i_if_req && run_cnt_q != RUN_MAX) ? run_cnt_q + 1'b1 : run_cnt_q;
      end else if (i_if_req) begin
        state_d = IF_BUSY;
        mem_req_d = 1'b1;
        mem_we_d = 1'b0;
        mem_addr_d = i_if_addr;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        run_cnt_d = '0;
      end
    end else if (ack) begin
      state_d = IDLE;
      mem_req_d = 1'b0;
      if (state_q == IF_BUSY) begin
        if_rdata_d = mem_addr_q[2] ? i_mem_rdata[MEM_DATA_W-1:INST_W] : i_mem_rdata[INST_W-1:0];
        if_valid_d = !drop_q && !i_if_flush;
      end else begin
        d_rdata_d = i_mem_rdata;
        d_valid_d = 1'b1;
      end
    end
    drop_d = (state_q == IF_BUSY && !ack) ? (drop_q || i_if_flush) : 1'b0;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      run_cnt_q <= '0;
      drop_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      d_rdata_q <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_cnt_q <= run_cnt_d;
      drop_q <= drop_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q <= if_rdata_d;
      if_valid_q <= if_valid_d;
      d_rdata_q <= d_rdata_d;
      d_valid_q <= d_valid_d;
    end
  end
  assign o_mem_req = mem_req_q;
  assign o_mem_we = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign o_if_rdata = if_rdata_q;
  assign o_if_valid = if_valid_q;
  assign o_d_rdata = d_rdata_q;
  assign o_d_valid = d_valid_q;
  assign o_if_stall = i_if_req && !if_valid_q;
  assign o_d_stall = i_d_req && !d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int MAXR = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, if_flush = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [7:0] d_wstrb = '0;
  logic [31:0] o_if_rdata;
  logic o_if_valid, o_if_stall, o_d_valid, o_d_stall, o_mem_req, o_mem_we;
  logic [63:0] o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0] o_mem_wstrb;
  int errs = 0, checks = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DATA_RUN(MAXR)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_wstrb(d_wstrb),
    .o_d_rdata(o_d_rdata), .o_d_valid(o_d_valid), .o_d_stall(o_d_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  bit busy, is_fetch, killed;
  logic m_req, m_we, e_ifv, e_dv, e_dload;
  logic [63:0] m_addr, m_wdata, e_dr;
  logic [7:0] m_wstrb;
  logic [31:0] e_ifr;
  int runs;
  always @(posedge clk) begin
    if (rst) begin
      busy = 0; is_fetch = 0; killed = 0; runs = 0;
      m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
      e_ifv = 0; e_dv = 0; e_dload = 0; e_ifr = 0; e_dr = 0;
    end else begin
      e_ifv = 0;
      e_dv = 0;
      if (!busy) begin
        if (d_req && !(if_req && runs == MAXR)) begin
          busy = 1; is_fetch = 0; m_req = 1;
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
          if (if_req && runs < MAXR) runs++;
        end else if (if_req) begin
          busy = 1; is_fetch = 1; m_req = 1;
          m_we = 0; m_addr = if_addr; m_wstrb = 0;
          runs = 0;
        end
      end else begin
        killed = killed || (is_fetch && if_flush);
        if (mem_ack) begin
          busy = 0;
          m_req = 0;
          if (is_fetch) begin
            e_ifr = 32'(mem_rdata >> (m_addr[2] ? 32 : 0));
            e_ifv = !killed;
          end else begin
            e_dr = mem_rdata;
            e_dv = 1;
            e_dload = !m_we;
          end
          killed = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", 64'(o_mem_req), 64'(m_req));
      chk("mem_we", 64'(o_mem_we), 64'(m_we));
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_wstrb", 64'(o_mem_wstrb), 64'(m_wstrb));
      if (m_we) chk("mem_wdata", o_mem_wdata, m_wdata);
      chk("if_valid", 64'(o_if_valid), 64'(e_ifv));
      chk("d_valid", 64'(o_d_valid), 64'(e_dv));
      if (e_ifv) chk("if_rdata", 64'(o_if_rdata), 64'(e_ifr));
      if (e_dv && e_dload) chk("d_rdata", o_d_rdata, e_dr);
      chk("if_stall", 64'(o_if_stall), 64'(if_req && !e_ifv));
      chk("d_stall", 64'(o_d_stall), 64'(d_req && !e_dv));
    end
  end
  initial begin
    logic [63:0] gq[$];
    logic prev;
    int nv;
    tick();
    tick();
    chk_en = 1;
    chk("rst_mem_req", 64'(o_mem_req), 64'h0);
    chk("rst_valids", 64'({o_if_valid, o_d_valid}), 64'h0);
    chk("rst_addr", o_mem_addr, 64'h0);
    chk("rst_rdata", 64'(o_if_rdata) | o_d_rdata, 64'h0);
    rst = 0;
    tick();
    if_req = 1; if_addr = 64'h1004;
    #1;
    chk("f_stall_c0", 64'(o_if_stall), 64'h1);
    tick();
    chk("f_req_c1", 64'(o_mem_req), 64'h1);
    chk("f_addr_c1", o_mem_addr, 64'h1004);
    mem_ack = 1; mem_rdata = 64'hAAAA_BBBB_1111_2222;
    #1;
    chk("f_stall_c1", 64'(o_if_stall), 64'h1);
    tick();
    chk("f_valid_c2", 64'(o_if_valid), 64'h1);
    chk("f_rdata_c2", 64'(o_if_rdata), 64'hAAAA_BBBB);
    chk("f_stall_c2", 64'(o_if_stall), 64'h0);
    if_req = 0; mem_ack = 0;
    tick();
    chk("f_valid_c3", 64'(o_if_valid), 64'h0);
    if_req = 1; if_addr = 64'h100; d_req = 1; d_we = 0; d_addr = 64'h200; mem_ack = 1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_mem_req && !prev) gq.push_back(o_mem_addr);
      prev = o_mem_req;
    end
    if_req = 0; d_req = 0;
    tick();
    mem_ack = 0;
    chk("grant_cnt", 64'(gq.size()), 64'd10);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      chk($sformatf("grant_%0d", i), gq[i], (i % 5 == 4) ? 64'h100 : 64'h200);
    tick();
    d_req = 1; d_we = 1; d_addr = 64'h80; d_wdata = 64'h0123_4567_89AB_CDEF; d_wstrb = 8'h0F; mem_rdata = '0;
    nv = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 6) begin
        chk("st_req_we", 64'({o_mem_req, o_mem_we}), 64'h3);
        chk("st_addr", o_mem_addr, 64'h80);
        chk("st_wdata", o_mem_wdata, 64'h0123_4567_89AB_CDEF);
        chk("st_wstrb", 64'(o_mem_wstrb), 64'h0F);
      end
      nv += int'(o_d_valid);
      mem_ack = (c == 6);
      if (c == 7) d_req = 0;
    end
    chk("st_valid_pulses", 64'(nv), 64'd1);
    d_we = 0;
    if_req = 1; if_addr = 64'h3000; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    nv = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      nv += int'(o_if_valid);
      if_flush = (c == 1);
      if (c == 1) if_req = 0;
      mem_ack = (c == 4);
    end
    chk("flush_no_valid", 64'(nv), 64'd0);
    if_req = 1; if_addr = 64'h2000;
    tick();
    mem_ack = 1; mem_rdata = 64'h5555_6666_7777_8888;
    tick();
    chk("post_flush_valid", 64'(o_if_valid), 64'h1);
    chk("post_flush_rdata", 64'(o_if_rdata), 64'h7777_8888);
    if_req = 0; mem_ack = 0;
    tick();
    d_req = 1; d_we = 0; d_addr = 64'h40;
    tick();
    chk("rst_mid_req_before", 64'(o_mem_req), 64'h1);
    rst = 1;
    tick();
    rst = 0; d_req = 0; mem_ack = 1;
    chk("rst_mid_req_after", 64'(o_mem_req), 64'h0);
    nv = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nv += int'(o_d_valid) + int'(o_mem_req);
    end
    chk("rst_mid_quiet", 64'(nv), 64'd0);
    for (int c = 0; c < 3; c++) begin
      mem_rdata = {$urandom, $urandom};
      tick();
      chk("spur_quiet", 64'({o_if_valid, o_d_valid, o_mem_req}), 64'h0);
      chk("spur_rdata", 64'(o_if_rdata) | o_d_rdata, 64'h0);
    end
    mem_ack = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom};
      if (if_flush || !if_req || e_ifv) begin
        if_flush = 0;
        if_req = ($urandom_range(0, 1) == 1);
        if_addr = 64'({$urandom_range(0, 1023), 2'b00});
      end else if ($urandom_range(0, 11) == 0) begin
        if_flush = 1;
      end
      if (!d_req || e_dv) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = ($urandom_range(0, 1) == 1);
        d_addr = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        d_wstrb = 8'($urandom);
      end
    end
    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
